parte_controllo: RTL and testbench
==================================

Name: parte_controllo

Overview:
- Control unit (Moore FSM) of the pixel run-length serial transmitter.
- Sequences the datapath that receives pixels over a dav_/rfd handshake and counts runs of equal colour.
- On a colour change or end of line, drives the datapath to shift a 10-bit asynchronous-style frame out on txd.
- Emits only mux-select lines b[9:0] to the datapath; reads back two datapath status bits plus the external dav_ and endline.

Parameters:
- FRAME_LAST, 0, COUNT value at which the last serial bit is being sent; exit condition of the shift state.

Ports:
- clock    input   1   system clock; all state changes on the rising edge.
- reset_   input   1   synchronous reset, ACTIVE-HIGH despite the name; sampled on the rising clock edge.
- dav_     input   1   producer data-valid, active low.
- endline  input   1   producer end-of-line flag, qualified by dav_=0.
- c_same   input   1   datapath status: 1 when incoming colore equals stored COLORE.
- c_zero   input   1   datapath status: 1 when datapath COUNT == FRAME_LAST.
- b        output  10  datapath select vector (field encoding below).

Behaviour:
- States: S0 (request), S1 (accumulate), S2 (load frame), S3 (shift), S4 (acknowledge). Encoding is free.
- Reset:
  - reset_=1 at a rising edge puts the FSM in S0, overriding any transition, including mid-frame in S3.
  - b is a pure combinational decode of the state, so b=0x329 from the edge that applied reset.
- Transitions, evaluated each rising edge with reset_=0:
  - S0: dav_=0 -> S1; else stay in S0.
  - S1: endline=1 OR c_same=0 -> S2; else -> S4.
  - S2: -> S3 unconditionally.
  - S3: c_zero=1 -> S4; else stay in S3.
    - COUNT is loaded with 9 in S2, so S3 lasts exactly 10 cycles.
  - S4: dav_=1 -> S0; else stay in S4.
- Datapath field encoding:
  - N select {b0,b1}: 00 count-if-same, 01 restart, 10 hold.
  - COUNT select {b3,b2}: 00 decrement, 01 load 9, 10 hold.
  - BUFFER select {b5,b4}: 00 load frame, 01 shift right, 10 hold.
  - RFD select {b7,b6}: 00 set, 01 clear, 10 hold.
  - COLORE select b8: 0 load, 1 hold.
  - TXD select b9: 0 load BUFFER[0], 1 hold.
- Output vector b[9:0] per state (Moore, glitch-free decode):
  - S0 = 0x329: RFD set, everything else held.
  - S1 = 0x3A8: N count-if-same, rest held.
  - S2 = 0x286: N restart, COUNT load 9, BUFFER load, COLORE load, RFD/TXD held.
  - S3 = 0x191: TXD load, BUFFER shift, COUNT decrement, N/RFD/COLORE held.
  - S4 = 0x369: RFD clear, rest held.
- Only the encodings above are ever emitted; the reserved 11 codes of the 2-bit fields are never produced.
- Handshake rule: a new pixel is consumed only in S0→S1, i.e. with rfd high. S4 keeps rfd low until dav_ returns high, so one dav_ low pulse is one pixel.
- Unreachable state codes return to S0 on the next edge, with b=0x329 while there.
- dav_, endline and status inputs are used only in the states listed; they are ignored elsewhere.

Test Plan:
- Reset: assert reset_=1 for one edge in any state, including mid-S3 -> next state S0, b=0x329. Release reset_ with dav_=1 -> stays S0 indefinitely.
- Same-colour pixel: dav_=0, endline=0, c_same=1 -> b sequence 0x329, 0x3A8, 0x369. Holds 0x369 until dav_=1, then 0x329.
- Colour change: dav_=0, c_same=0, endline=0 -> 0x3A8, 0x286, then 0x191. Hold c_zero=0 for 9 cycles and raise it on the 10th -> exactly 10 cycles of 0x191, then 0x369.
- End of line: dav_=0, endline=1, c_same=1 -> S1 then S2 (0x286) -> full S3 frame -> S4.
- Slow producer: in S4 keep dav_=0 for 5 cycles -> b stays 0x369 for 5 cycles. No S0/S1 re-entry, so no double count.
- Status ignored elsewhere: toggle c_zero in S0/S1/S4 and c_same in S3 -> no change in transitions from the table.

Source files
------------

// File: rtl/parte_controllo.sv
// parte_controllo: Moore control unit of the pixel run-length serial transmitter.
//
// It sequences the datapath that takes pixels over a dav_/rfd handshake,
// counts runs of equal colour, and shifts a 10-bit frame out on txd when the
// colour changes or the line ends.
//
// Ports:
//   clock       rising-edge system clock
//   reset_      synchronous reset, active HIGH despite the trailing underscore
//   dav_        producer data-valid, active low
//   endline     producer end-of-line flag, meaningful only with dav_=0
//   c_same      datapath status: incoming colore equals stored COLORE
//   c_zero      datapath status: COUNT == FRAME_LAST (last serial bit)
//   b[9:0]      datapath select vector, decoded from the state register
//   state_dbg   current state code, for checkers and debug
//   frame_sync  high while in S3 on the cycle the local bit index reaches
//               FRAME_LAST; it mirrors the datapath COUNT for cross-checking c_zero
//
// Handshake: a pixel is taken only on the S0->S1 edge, i.e. while rfd is set
// and dav_ is low. S4 clears rfd and waits for dav_ to go high again, so one
// dav_ low pulse is exactly one pixel, however long the producer holds it.

module parte_controllo #(
  parameter int unsigned FRAME_LAST = 0
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       dav_,
  input  logic       endline,
  input  logic       c_same,
  input  logic       c_zero,
  output logic [9:0] b,
  output logic [2:0] state_dbg,
  output logic       frame_sync
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // request: rfd set, wait for a pixel
    S1 = 3'd1,  // accumulate: count if same colour
    S2 = 3'd2,  // load frame, restart run, load COUNT=9
    S3 = 3'd3,  // shift the frame out on txd
    S4 = 3'd4   // acknowledge: rfd clear until dav_ returns high
  } state_t;

  // Select vectors per state. Field layout (bit positions):
  //   {b0,b1} N, {b3,b2} COUNT, {b5,b4} BUFFER, {b7,b6} RFD, b8 COLORE, b9 TXD
  localparam logic [9:0] B_S0 = 10'h329;
  localparam logic [9:0] B_S1 = 10'h3A8;
  localparam logic [9:0] B_S2 = 10'h286;
  localparam logic [9:0] B_S3 = 10'h191;
  localparam logic [9:0] B_S4 = 10'h369;

  state_t     state;
  logic [3:0] bit_idx;

  always_ff @(posedge clock) begin
    if (reset_) begin
      state   <= S0;
      bit_idx <= 4'd0;
    end else begin
      case (state)
        S0: if (!dav_) state <= S1;
        S1: state <= (endline || !c_same) ? S2 : S4;
        S2: begin
          state   <= S3;
          bit_idx <= 4'd9;
        end
        S3: begin
          if (c_zero) state <= S4;
          if (bit_idx != 4'd0) bit_idx <= bit_idx - 4'd1;
        end
        S4: if (dav_) state <= S0;
        // Codes 5..7 are unreachable; fall back to the request state.
        default: state <= S0;
      endcase
    end
  end

  // Pure decode of the state register, so b changes only on the clock edge.
  always_comb begin
    b = B_S0;
    case (state)
      S0:      b = B_S0;
      S1:      b = B_S1;
      S2:      b = B_S2;
      S3:      b = B_S3;
      S4:      b = B_S4;
      default: b = B_S0;
    endcase
  end

  assign state_dbg  = state;
  assign frame_sync = (state == S3) && (bit_idx == 4'(FRAME_LAST));

endmodule

// File: tb/tb_parte_controllo.sv
// Directed testbench for parte_controllo. The driver applies one input vector
// per clock and pushes the hand-computed b expected after that edge; a monitor
// pops and compares on every falling edge.

module tb_parte_controllo;

  localparam logic [9:0] B_S0 = 10'h329;
  localparam logic [9:0] B_S1 = 10'h3A8;
  localparam logic [9:0] B_S2 = 10'h286;
  localparam logic [9:0] B_S3 = 10'h191;
  localparam logic [9:0] B_S4 = 10'h369;

  // clock / reset
  logic clock = 1'b0;
  logic reset_ = 1'b1;
  logic dav_ = 1'b1;
  logic endline = 1'b0;
  logic c_same = 1'b0;
  logic c_zero = 1'b0;
  logic [9:0] b;
  logic [2:0] state_dbg;
  logic frame_sync;

  always #5 clock = ~clock;

  parte_controllo #(.FRAME_LAST(0)) dut (
    .clock      (clock),
    .reset_     (reset_),
    .dav_       (dav_),
    .endline    (endline),
    .c_same     (c_same),
    .c_zero     (c_zero),
    .b          (b),
    .state_dbg  (state_dbg),
    .frame_sync (frame_sync)
  );

  // scoreboard
  logic [9:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;
  int pop_no = 0;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      checks++;
      pop_no++;
      if (b !== e) begin
        errors++;
        $display("FAIL b_step%0d: got 0x%03h expected 0x%03h", pop_no, b, e);
      end
    end
  end

  // driver: one clock edge with the given inputs, then queue the expected b
  task automatic step(input logic rst, input logic dv, input logic el,
                      input logic cs, input logic cz, input logic [9:0] exp_b);
    @(negedge clock);
    reset_  = rst;
    dav_    = dv;
    endline = el;
    c_same  = cs;
    c_zero  = cz;
    @(posedge clock);
    #1;
    exp_q.push_back(exp_b);
    step_no++;
  endtask

  // Full frame from S2 onward: entry into S3, nine more S3 cycles with c_zero
  // low (c_same toggled, must be ignored), then c_zero high to S4.
  task automatic shift_frame();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, B_S3);
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b0, 1'b0, 1'(i % 2), 1'b0, B_S3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, B_S4);
  endtask

  initial begin
    // reset and idle with dav_ high; c_zero toggled in S0 is ignored
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, B_S0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, B_S0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, B_S0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, B_S0);

    // same-colour pixel, then slow producer holding dav_ low in S4
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, B_S1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, B_S4);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b0, 1'(i % 2), 1'b1, B_S4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, B_S0);

    // colour change: S1 -> S2 -> 10 cycles of S3 -> S4
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, B_S1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, B_S2);
    shift_frame();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, B_S0);

    // end of line with the same colour still sends a frame
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, B_S1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, B_S2);
    shift_frame();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, B_S0);

    // reset mid-S3
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, B_S1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, B_S2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, B_S3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, B_S3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, B_S0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, B_S0);

    // reset in S4 with dav_ low, then a fresh pixel is accepted
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, B_S1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, B_S4);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, B_S0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, B_S1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, B_S4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, B_S0);

    // drain the scoreboard with a bounded wait
    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
        @(posedge clock);
        waited++;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
    end
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
